instruction_fetch: RTL and testbench

//  Fetch stage feeding the decoder / immediate-extract logic. Owns the PC and

---
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, one read in flight, small instruction queue.
// Define FETCH_MISALIGN_TRAP_EN to fault on misaligned redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fault_q, fault_d;

    logic [31:0]   qdata_q [QUEUE_DEPTH];
    logic [31:0]   qpc_q   [QUEUE_DEPTH];

    logic [31:0]   tgt_pc;
    logic          tgt_bad;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nx;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_pc  = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    assign tgt_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign tgt_bad = 1'b0;
`endif

    assign inst_valid = (count_q != '0);
    assign inst       = qdata_q[rd_ptr_q];
    // While faulted the queue is empty; the head PC reports the bad target.
    assign inst_pc    = fault_q ? pc_q : qpc_q[rd_ptr_q];
    assign mem_req    = (state_q == REQ);
    assign mem_addr   = {pc_q[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign push     = (state_q == WAIT) && mem_rvalid && !redirect;
    assign pop      = inst_valid && inst_ready && !redirect;
    assign count_nx = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fault_d  = fault_q;
        if (redirect) begin
            pc_d     = tgt_pc;
            fault_d  = tgt_bad;
            count_d  = '0;
            wr_ptr_d = rd_ptr_q;
            unique case (state_q)
                IDLE:    state_d = tgt_bad ? IDLE : REQ;
                REQ:     state_d = mem_ack ? DISCARD
                                           : (tgt_bad ? IDLE : REQ);
                WAIT:    state_d = mem_rvalid ? (tgt_bad ? IDLE : REQ)
                                              : DISCARD;
                DISCARD: state_d = mem_rvalid ? (tgt_bad ? IDLE : REQ)
                                              : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_nx;
            unique case (state_q)
                IDLE: begin
                    if (!fault_q && (count_q < DEPTH_C)) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_d = (count_nx < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_rvalid) begin
                        state_d = fault_q ? IDLE : REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[wr_ptr_q] <= mem_rdata;
            qpc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency memory model.
// Define FETCH_MISALIGN_TRAP_EN to exercise the misaligned-target fault.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    int          lat;
    logic        ack_en;
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];

    instruction_fetch #(
        .RESET_PC    (32'h0000_0100),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    assign mem_ack = ack_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    // Memory: accepts on mem_req && mem_ack, answers lat cycles later.
    initial begin : memory
        logic        acc;
        logic [31:0] acc_addr;
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        pend       = 1'b0;
        cnt        = 0;
        paddr      = '0;
        forever begin
            @(negedge clk);
            acc      = (mem_req === 1'b1) && (mem_ack === 1'b1);
            acc_addr = mem_addr;
            if (acc && !reset) acc_log.push_back(acc_addr);
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = acc_addr;
                end
                if (pend) begin
                    cnt = cnt - 1;
                    if (cnt <= 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_word(paddr);
                        pend       = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && !redirect && inst_valid === 1'b1 && inst_ready) begin
            pop_pc.push_back(inst_pc);
            pop_data.push_back(inst);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_pc.delete();
        pop_data.delete();
    endtask

    task automatic start(input int l, input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = l;
        ack_en      = 1'b1;
        inst_ready  = rdy;
        repeat (3) tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        logic [31:0] exp3 [3];
        logic [31:0] got;
        exp3[0] = 32'h100;
        exp3[1] = 32'h104;
        exp3[2] = 32'h108;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = 1;
        ack_en      = 1'b1;
        inst_ready  = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_req: got %b expected 0", mem_req);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_inst_valid: got %b expected 0", inst_valid);
        end
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_fault: got %b expected 0", fetch_fault);
        end
        tick();
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h expected 1/00000100",
                     mem_req, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_valid: got %b expected 0", inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 ||
            inst !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL first_inst: got v=%b pc=%h i=%h expected 1/%h/%h",
                     inst_valid, inst_pc, inst, 32'h100, mem_word(32'h100));
        end
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp3[i]) begin
                failures++;
                $display("FAIL reset_addr_seq[%0d]: got %h expected %h",
                         i, got, exp3[i]);
            end
            got = (i < pop_pc.size()) ? pop_pc[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp3[i]) begin
                failures++;
                $display("FAIL reset_pc_seq[%0d]: got %h expected %h",
                         i, got, exp3[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp3 [3];
        logic [31:0] got;
        exp3[0] = 32'h100;
        exp3[1] = 32'h104;
        exp3[2] = 32'h108;
        start(1, 1'b0);
        repeat (12) @(negedge clk);
        checks++;
        if (acc_log.size() != 2) begin
            failures++;
            $display("FAIL bp_req_count: got %0d expected 2", acc_log.size());
        end
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_req_idle: got %b expected 0", mem_req);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 ||
            inst !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL bp_head: got v=%b pc=%h i=%h expected 1/%h/%h",
                     inst_valid, inst_pc, inst, 32'h100, mem_word(32'h100));
        end
        tick();
        clear_logs();
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);
        got = (acc_log.size() > 0) ? acc_log[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h108) begin
            failures++;
            $display("FAIL bp_resume_addr: got %h expected 00000108", got);
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_pc.size()) ? pop_pc[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp3[i]) begin
                failures++;
                $display("FAIL bp_pc_seq[%0d]: got %h expected %h",
                         i, got, exp3[i]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] got;
        start(3, 1'b1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rw_discard: got v=%b req=%b expected 0/0",
                     inst_valid, mem_req);
        end
        repeat (20) @(negedge clk);
        got = (acc_log.size() > 0) ? acc_log[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h200) begin
            failures++;
            $display("FAIL rw_addr: got %h expected 00000200", got);
        end
        got = (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h200) begin
            failures++;
            $display("FAIL rw_first_pc: got %h expected 00000200", got);
        end
        got = (pop_pc.size() > 1) ? pop_pc[1] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h204) begin
            failures++;
            $display("FAIL rw_second_pc: got %h expected 00000204", got);
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_data[i] !== mem_word(pop_pc[i])) begin
                failures++;
                $display("FAIL rw_data[%0d]: got %h expected %h",
                         i, pop_data[i], mem_word(pop_pc[i]));
            end
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        logic [31:0] got;
        start(1, 1'b0);
        repeat (4) tick();
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
            failures++;
            $display("FAIL rrp_pre: got v=%b pc=%h expected 1/00000100",
                     inst_valid, inst_pc);
        end
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rrp_empty: got %b expected 0", inst_valid);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL rrp_req: got req=%b addr=%h expected 1/00000300",
                     mem_req, mem_addr);
        end
        tick();
        inst_ready = 1'b1;
        repeat (10) @(negedge clk);
        got = (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h300) begin
            failures++;
            $display("FAIL rrp_first_pc: got %h expected 00000300", got);
        end
        got = (pop_pc.size() > 1) ? pop_pc[1] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h304) begin
            failures++;
            $display("FAIL rrp_second_pc: got %h expected 00000304", got);
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_data[i] !== mem_word(pop_pc[i])) begin
                failures++;
                $display("FAIL rrp_data[%0d]: got %h expected %h",
                         i, pop_data[i], mem_word(pop_pc[i]));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp3 [3];
        logic [31:0] got;
        exp3[0] = 32'hFFFF_FFFC;
        exp3[1] = 32'h0000_0000;
        exp3[2] = 32'h0000_0004;
        start(1, 1'b1);
        repeat (5) tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        clear_logs();
        repeat (14) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp3[i]) begin
                failures++;
                $display("FAIL wrap_addr[%0d]: got %h expected %h",
                         i, got, exp3[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < pop_pc.size()) ? pop_pc[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp3[i]) begin
                failures++;
                $display("FAIL wrap_pc[%0d]: got %h expected %h",
                         i, got, exp3[i]);
            end
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_data[i] !== mem_word(pop_pc[i])) begin
                failures++;
                $display("FAIL wrap_data[%0d]: got %h expected %h",
                         i, pop_data[i], mem_word(pop_pc[i]));
            end
        end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        logic [31:0] got;
        start(1, 1'b1);
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || mem_req !== 1'b0 ||
            inst_valid !== 1'b0 || inst_pc !== 32'h202) begin
            failures++;
            $display("FAIL mis_fault: got f=%b req=%b v=%b pc=%h expected 1/0/0/00000202",
                     fetch_fault, mem_req, inst_valid, inst_pc);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || mem_req !== 1'b0 ||
            acc_log.size() != 0) begin
            failures++;
            $display("FAIL mis_hold: got f=%b req=%b reqs=%0d expected 1/0/0",
                     fetch_fault, mem_req, acc_log.size());
        end
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b0 || mem_req !== 1'b1 ||
            mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL mis_clear: got f=%b req=%b addr=%h expected 0/1/00000300",
                     fetch_fault, mem_req, mem_addr);
        end
        repeat (8) @(negedge clk);
        got = (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h300) begin
            failures++;
            $display("FAIL mis_first_pc: got %h expected 00000300", got);
        end
    endtask
`else
    task automatic test_unaligned_ignored();
        logic [31:0] got;
        start(1, 1'b1);
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        tick();
        redirect = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b0 || mem_req !== 1'b1 ||
            mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL unal_req: got f=%b req=%b addr=%h expected 0/1/00000300",
                     fetch_fault, mem_req, mem_addr);
        end
        repeat (8) @(negedge clk);
        got = (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'h300) begin
            failures++;
            $display("FAIL unal_first_pc: got %h expected 00000300", got);
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_data[i] !== mem_word(pop_pc[i])) begin
                failures++;
                $display("FAIL unal_data[%0d]: got %h expected %h",
                         i, pop_data[i], mem_word(pop_pc[i]));
            end
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        ack_en      = 1'b1;
        lat         = 1;
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid_pop();
        test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_unaligned_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
